// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - posit formats, operations, rounding modes and status flags
package posit_pkg;

    typedef enum logic [1:0] {
        POSIT16_ES1 = 2'd0,
        POSIT8_ES0  = 2'd1,
        POSIT32_ES2 = 2'd2
    } posit_format_e;

    function automatic int unsigned posit_width(posit_format_e fmt);
        case (fmt)
            POSIT8_ES0:  return 8;
            POSIT32_ES2: return 32;
            default:     return 16;
        endcase
    endfunction

    typedef enum logic {
        DIV  = 1'b0,
        SQRT = 1'b1
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } roundmode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

endpackage

// File: rtl/posit_divsqrt_ctrl.sv
// rtl/posit_divsqrt_ctrl.sv - single-outstanding request/response controller for posit_divsqrt
// Optional watchdog: define POSIT_DIVSQRT_CTRL_TIMEOUT_EN.
module posit_divsqrt_ctrl #(
    parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned WIDTH = posit_pkg::posit_width(pFormat)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [1:0][WIDTH-1:0]        req_operands_i,
    input  posit_pkg::operation_e        req_op_i,
    input  posit_pkg::roundmode_e        req_rnd_mode_i,
    input  logic                         req_tag_i,
    input  logic                         flush_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [WIDTH-1:0]             rsp_result_o,
    output posit_pkg::status_t           rsp_status_o,
    output logic                         rsp_tag_o,
    output logic [1:0][WIDTH-1:0]        unit_operands_o,
    output posit_pkg::operation_e        unit_op_o,
    output posit_pkg::roundmode_e        unit_rnd_mode_o,
    output logic                         unit_tag_o,
    output logic                         unit_in_valid_o,
    input  logic                         unit_in_ready_i,
    output logic                         unit_flush_o,
    input  logic [WIDTH-1:0]             unit_result_i,
    input  posit_pkg::status_t           unit_status_i,
    input  logic                         unit_tag_i,
    input  logic                         unit_out_valid_i,
    output logic                         unit_out_ready_o,
    output logic                         busy_o
);
    import posit_pkg::*;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                 state_q, state_d;
    logic [1:0][WIDTH-1:0]  opnd_q, opnd_d;
    operation_e             op_q, op_d;
    roundmode_e             rnd_q, rnd_d;
    logic                   tag_q, tag_d;
    logic [WIDTH-1:0]       res_q, res_d;
    status_t                st_q, st_d;
    logic                   rtag_q, rtag_d;

    logic accept, tag_hit, capture, timeout;

    assign req_ready_o = ~flush_i & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready_i));
    assign accept      = req_valid_i & req_ready_o;
    assign tag_hit     = unit_out_valid_i & (unit_tag_i == tag_q);
    assign capture     = ((state_q == ISSUE) & unit_in_ready_i & tag_hit) | ((state_q == WAIT) & tag_hit);

`ifdef POSIT_DIVSQRT_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == ISSUE && state_q != ISSUE) begin
            cnt_d = '0;
        end else if (state_q == ISSUE || state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // A capture in the expiring cycle wins, so the watchdog only fires without one.
    assign timeout      = (state_q == ISSUE || state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !capture;
    assign unit_flush_o = flush_i | timeout;
`else
    // TIMEOUT_CYCLES only has an effect when the watchdog is built in.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
    assign timeout      = 1'b0;
    assign unit_flush_o = flush_i;
`endif

    always_comb begin
        state_d          = state_q;
        opnd_d           = opnd_q;
        op_d             = op_q;
        rnd_d            = rnd_q;
        tag_d            = tag_q;
        res_d            = res_q;
        st_d             = st_q;
        rtag_d           = rtag_q;
        unit_in_valid_o  = 1'b0;
        unit_out_ready_o = 1'b0;
        rsp_valid_o      = 1'b0;

        case (state_q)
            IDLE: if (accept) state_d = ISSUE;
            ISSUE: begin
                unit_in_valid_o  = 1'b1;
                unit_out_ready_o = 1'b1;
                if (unit_in_ready_i) state_d = capture ? RESP : WAIT;
            end
            WAIT: begin
                unit_out_ready_o = 1'b1;
                if (capture) state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = accept ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            res_d  = unit_result_i;
            st_d   = unit_status_i;
            rtag_d = unit_tag_i;
        end else if (timeout) begin
            res_d   = {1'b1, {(WIDTH-1){1'b0}}};
            st_d    = status_t'(5'b10000);
            rtag_d  = tag_q;
            state_d = RESP;
        end

        if (accept) begin
            opnd_d[0] = req_operands_i[0];
            opnd_d[1] = (req_op_i == SQRT) ? '0 : req_operands_i[1];
            op_d      = req_op_i;
            rnd_d     = req_rnd_mode_i;
            tag_d     = req_tag_i;
        end

        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            op_q    <= DIV;
            rnd_q   <= RNE;
            tag_q   <= 1'b0;
            res_q   <= '0;
            st_q    <= status_t'(5'b0);
            rtag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            rnd_q   <= rnd_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            st_q    <= st_d;
            rtag_q  <= rtag_d;
        end
    end

    assign unit_operands_o = opnd_q;
    assign unit_op_o       = op_q;
    assign unit_rnd_mode_o = rnd_q;
    assign unit_tag_o      = tag_q;
    assign rsp_result_o    = res_q;
    assign rsp_status_o    = st_q;
    assign rsp_tag_o       = rtag_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_posit_divsqrt_ctrl.sv
// tb/tb_posit_divsqrt_ctrl.sv - directed scoreboard bench for posit_divsqrt_ctrl (16-bit, ES=1)
module tb_posit_divsqrt_ctrl;
    import posit_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic [4:0]  st;
        logic        tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0][15:0]  req_operands_i;
    operation_e        req_op_i;
    roundmode_e        req_rnd_mode_i;
    logic              req_tag_i;
    logic              flush_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [15:0]       rsp_result_o;
    status_t           rsp_status_o;
    logic              rsp_tag_o;
    logic [1:0][15:0]  unit_operands_o;
    operation_e        unit_op_o;
    roundmode_e        unit_rnd_mode_o;
    logic              unit_tag_o;
    logic              unit_in_valid_o;
    logic              unit_in_ready_i;
    logic              unit_flush_o;
    logic [15:0]       unit_result_i;
    status_t           unit_status_i;
    logic              unit_tag_i;
    logic              unit_out_valid_i;
    logic              unit_out_ready_o;
    logic              busy_o;

    logic in_rdy_en, out_en, late_mode, tag_flip;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    posit_divsqrt_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_operands_i(req_operands_i), .req_op_i(req_op_i),
        .req_rnd_mode_i(req_rnd_mode_i), .req_tag_i(req_tag_i),
        .flush_i(flush_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o), .rsp_tag_o(rsp_tag_o),
        .unit_operands_o(unit_operands_o), .unit_op_o(unit_op_o),
        .unit_rnd_mode_o(unit_rnd_mode_o), .unit_tag_o(unit_tag_o),
        .unit_in_valid_o(unit_in_valid_o), .unit_in_ready_i(unit_in_ready_i),
        .unit_flush_o(unit_flush_o),
        .unit_result_i(unit_result_i), .unit_status_i(unit_status_i),
        .unit_tag_i(unit_tag_i), .unit_out_valid_i(unit_out_valid_i),
        .unit_out_ready_o(unit_out_ready_o), .busy_o(busy_o)
    );

    // Combinational stand-in for the unit, knowing only the test-plan values.
    always_comb begin
        unit_in_ready_i  = in_rdy_en & unit_out_ready_o;
        unit_out_valid_i = out_en & (late_mode ? unit_out_ready_o : (unit_in_valid_o & unit_in_ready_i));
        unit_tag_i       = unit_tag_o ^ tag_flip;
        unit_result_i    = 16'h8000;
        unit_status_i    = status_t'(5'b10000);
        if (unit_op_o == SQRT) begin
            if (unit_operands_o[0] == 16'h6000) begin
                unit_result_i = 16'h5000;
                unit_status_i = status_t'(5'b00000);
            end
        end else if (unit_operands_o[1] == 16'h0000) begin
            unit_status_i = status_t'(5'b01000);
        end else if (unit_operands_o[1] == 16'h4000) begin
            unit_result_i = unit_operands_o[0];
            unit_status_i = status_t'(5'b00000);
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic sb_cmp();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_result", 32'(rsp_result_o), 32'(e.res));
            chk("rsp_status", 32'(rsp_status_o), 32'(e.st));
            chk("rsp_tag", 32'(rsp_tag_o), 32'(e.tag));
        end
    endtask

    // Drives one request for a single cycle; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input operation_e op, input logic [15:0] a, input logic [15:0] b,
                        input logic tag, input logic push, input exp_t e);
        @(posedge clk); #1;
        req_valid_i       = 1'b1;
        req_op_i          = op;
        req_operands_i[0] = a;
        req_operands_i[1] = b;
        req_tag_i         = tag;
        req_rnd_mode_i    = RNE;
        @(negedge clk);
        chk("req_ready_accept", 32'(req_ready_o), 32'd1);
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cyc, output int lat);
        lat = 0;
        while (!rsp_valid_o && lat < max_cyc) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid_seen", 32'(rsp_valid_o), 32'd1);
    endtask

    task automatic take_rsp();
        sb_cmp();
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int   lat;
        int   k;
        int   seen;
        logic held_ok;

        rst_i = 1'b1; req_valid_i = 1'b0; req_operands_i = '0; req_op_i = DIV;
        req_rnd_mode_i = RNE; req_tag_i = 1'b0; flush_i = 1'b0; rsp_ready_i = 1'b0;
        in_rdy_en = 1'b1; out_en = 1'b1; late_mode = 1'b0; tag_flip = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_unit_in_valid", 32'(unit_in_valid_o), 32'd0);
        chk("rst_unit_out_ready", 32'(unit_out_ready_o), 32'd0);
        chk("rst_unit_flush", 32'(unit_flush_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_result", 32'(rsp_result_o), 32'd0);
        chk("rst_status", 32'(rsp_status_o), 32'd0);
        chk("rst_tag", 32'(rsp_tag_o), 32'd0);

        // DIV 1.0 / 1.0, two-cycle latency
        send(DIV, 16'h4000, 16'h4000, 1'b1, 1'b1, '{res: 16'h4000, st: 5'b00000, tag: 1'b1});
        wait_rsp(10, lat);
        chk("div_latency", 32'(lat), 32'd2);
        take_rsp();
        @(negedge clk);
        chk("div_rsp_dropped", 32'(rsp_valid_o), 32'd0);
        chk("div_idle", 32'(busy_o), 32'd0);

        // DIV by zero
        send(DIV, 16'h4000, 16'h0000, 1'b0, 1'b1, '{res: 16'h8000, st: 5'b01000, tag: 1'b0});
        wait_rsp(10, lat);
        take_rsp();

        // SQRT with held response and back-to-back request
        send(SQRT, 16'h6000, 16'h1234, 1'b0, 1'b1, '{res: 16'h5000, st: 5'b00000, tag: 1'b0});
        @(negedge clk);
        chk("sqrt_opnd1_zero", 32'(unit_operands_o[1]), 32'd0);
        chk("sqrt_unit_op", 32'(unit_op_o), 32'(SQRT));
        wait_rsp(10, lat);
        held_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_result_o !== 16'h5000) held_ok = 1'b0;
        end
        chk("sqrt_rsp_held", 32'(held_ok), 32'd1);
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_op_i = DIV; req_tag_i = 1'b1;
        req_operands_i[0] = 16'h4000; req_operands_i[1] = 16'h4000;
        @(negedge clk);
        chk("b2b_req_ready", 32'(req_ready_o), 32'd1);
        sb_cmp();
        sb.push_back('{res: 16'h4000, st: 5'b00000, tag: 1'b1});
        @(posedge clk); #1;
        rsp_ready_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_issue_valid", 32'(unit_in_valid_o), 32'd1);
        chk("b2b_no_rsp", 32'(rsp_valid_o), 32'd0);
        wait_rsp(10, lat);
        chk("b2b_latency", 32'(lat), 32'd1);
        take_rsp();

        // flush while stalled in ISSUE
        in_rdy_en = 1'b0;
        send(DIV, 16'h4000, 16'h4000, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("stall_in_valid", 32'(unit_in_valid_o), 32'd1);
        @(negedge clk);
        chk("stall_opnd_stable", 32'(unit_operands_o[0]), 32'h4000);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_unit_flush", 32'(unit_flush_o), 32'd1);
        chk("flush_req_ready", 32'(req_ready_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; in_rdy_en = 1'b1;
        @(negedge clk);
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_unit_flush_off", 32'(unit_flush_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid_o) seen++;
        end
        chk("flush_no_rsp", 32'(seen), 32'd0);

        // flush beats accept
        @(posedge clk); #1;
        req_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("flush_vs_accept", 32'(busy_o), 32'd0);

        // reset while holding a response
        send(DIV, 16'h5000, 16'h4000, 1'b1, 1'b1, '{res: 16'h5000, st: 5'b00000, tag: 1'b1});
        wait_rsp(10, lat);
        chk("pre_rst_result", 32'(rsp_result_o), 32'h5000);
        if (sb.size() != 0) void'(sb.pop_front());
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_resp_ready", 32'(req_ready_o), 32'd1);
        chk("rst_resp_result", 32'(rsp_result_o), 32'd0);

        // WAIT path with a mismatched tag first
        out_en = 1'b0;
        send(DIV, 16'h6000, 16'h4000, 1'b1, 1'b1, '{res: 16'h6000, st: 5'b00000, tag: 1'b1});
        @(negedge clk);
        @(negedge clk);
        chk("wait_in_valid", 32'(unit_in_valid_o), 32'd0);
        chk("wait_out_ready", 32'(unit_out_ready_o), 32'd1);
        late_mode = 1'b1; tag_flip = 1'b1; out_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wait_bad_tag_ignored", 32'(rsp_valid_o), 32'd0);
        tag_flip = 1'b0;
        wait_rsp(10, lat);
        take_rsp();
        late_mode = 1'b0;

`ifdef POSIT_DIVSQRT_CTRL_TIMEOUT_EN
        out_en = 1'b0;
        send(DIV, 16'h4000, 16'h4000, 1'b1, 1'b1, '{res: 16'h8000, st: 5'b10000, tag: 1'b1});
        k = 0;
        seen = 0;
        while (seen == 0 && k < 20) begin
            @(negedge clk);
            k++;
            if (unit_flush_o) seen = k;
        end
        chk("timeout_flush_cycle", 32'(seen), 32'd5);
        wait_rsp(3, lat);
        chk("timeout_flush_pulse", 32'(unit_flush_o), 32'd0);
        take_rsp();
        out_en = 1'b1;
`else
        k = 0;
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/posit_divsqrt_ctrl.md
Name: posit_divsqrt_ctrl

Overview:
Initiator-side controller for the posit div/sqrt unit's valid/ready/flush/tag interface. It accepts one request at a time from the core, registers it, and drives the unit's input handshake. It then collects the unit's result, status and tag, and holds the response for the core until it is taken. It sits between the core's posit issue stage and posit_divsqrt.

Parameters:
pFormat, posit_pkg::posit_format_e'(0), posit format; localparam WIDTH = posit_pkg::posit_width(pFormat)
TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  core request ready
req_operands_i  in  2xWIDTH  operands; [1] is unused for SQRT
req_op_i  in  posit_pkg::operation_e  DIV or SQRT
req_rnd_mode_i  in  posit_pkg::roundmode_e  rounding mode
req_tag_i  in  1  request tag
flush_i  in  1  kill in-flight work
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  core response ready
rsp_result_o  out  WIDTH  result posit
rsp_status_o  out  posit_pkg::status_t  status flags
rsp_tag_o  out  1  response tag
unit_operands_o  out  2xWIDTH  to unit
unit_op_o  out  operation_e  to unit
unit_rnd_mode_o  out  roundmode_e  to unit
unit_tag_o  out  1  to unit
unit_in_valid_o  out  1  to unit
unit_in_ready_i  in  1  from unit
unit_flush_o  out  1  to unit
unit_result_i  in  WIDTH  from unit
unit_status_i  in  status_t  from unit
unit_tag_i  in  1  from unit
unit_out_valid_i  in  1  from unit
unit_out_ready_o  out  1  to unit
busy_o  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: state=IDLE and all registers are 0. After reset: req_ready_o=1, rsp_valid_o=0, unit_in_valid_o=0, unit_out_ready_o=0, unit_flush_o=0, busy_o=0, rsp_result_o=0, rsp_status_o=0, rsp_tag_o=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- req_ready_o = ~flush_i & (IDLE | (RESP & rsp_ready_i)).
- Request accept (req_valid_i & req_ready_o): register operands, op, rnd_mode and tag, then go to ISSUE. For SQRT, register operand[1] as 0.
- Back-to-back: a response taken in RESP and a new request accepted in the same cycle goes directly to ISSUE.
- unit_* data outputs always reflect the registered request.
- ISSUE:
  - unit_in_valid_o=1 and unit_out_ready_o=1.
  - On unit_in_ready_i: if unit_out_valid_i is also high with unit_tag_i == stored tag, capture result/status/tag and go to RESP. Otherwise go to WAIT.
  - Without unit_in_ready_i: stay in ISSUE, holding unit_in_valid_o and the data stable.
- WAIT:
  - unit_in_valid_o=0, unit_out_ready_o=1.
  - On unit_out_valid_i with matching tag: capture and go to RESP.
  - A mismatched tag is ignored; stay in WAIT.
- RESP:
  - rsp_valid_o=1 with the captured values, held stable until rsp_ready_i.
  - On rsp_ready_i: go to IDLE, or to ISSUE if a new request is accepted the same cycle.
- Latency: with a same-cycle unit, request accepted in cycle N, unit handshake in N+1, rsp_valid_o in N+2. Sustained throughput is one op per 2 cycles.
- flush_i:
  - unit_flush_o = flush_i (combinational), or the watchdog pulse (see Optional Feature).
  - Next state is IDLE from any state; any pending request or response is dropped, with no rsp_valid_o afterwards.
  - Flush beats a simultaneous accept or capture.
- Reset mid-operation: reset overrides everything, including flush and handshakes; next state IDLE.

Optional Feature:
POSIT_DIVSQRT_CTRL_TIMEOUT_EN
- With the macro: an 8-bit-minimum counter clears on entry to ISSUE and increments in ISSUE and WAIT. When it reaches TIMEOUT_CYCLES with no output capture:
  - unit_flush_o pulses for 1 cycle;
  - the response is forced to result = 1 followed by WIDTH-1 zeros (NaR), status = 5'b10000 (NV), tag = stored tag;
  - state goes to RESP.
  - A capture in the same cycle as the timeout wins.
- Without the macro: no counter; the FSM waits indefinitely and TIMEOUT_CYCLES is unused.

Test Plan:
Test format is 16-bit, ES=1; the unit is combinational with in_ready=out_ready.
- DIV 0x4000 / 0x4000, tag=1 -> rsp_valid_o 2 cycles after accept; result 0x4000, status 0, tag 1.
- DIV 0x4000 / 0x0000 -> result 0x8000, status 5'b01000.
- SQRT 0x6000 (4.0), with rsp_ready_i low for 3 cycles -> rsp held stable at 0x5000 (2.0); a new request taken the cycle rsp_ready_i rises.
- flush_i asserted in ISSUE with unit_in_ready_i low -> unit_flush_o=1 the same cycle, IDLE next cycle, no response; busy_o=0.
- rst_i asserted in RESP -> next cycle rsp_valid_o=0, req_ready_o=1, rsp_result_o=0.
- TIMEOUT_EN defined, TIMEOUT_CYCLES=4, unit_out_valid_i held 0 -> unit_flush_o pulse after 4 cycles; rsp 0x8000, status 5'b10000.
